// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Tightly-coupled data RAM slave on the req/gnt/rvalid bus.
//             Word-wide reads and byte-enabled writes with in-order responses
//             after a fixed LATENCY, plus grant-stall injection via busy_i.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        busy_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  // Byte span of the array; one bit wider so MEM_WORDS near 2^30 still fits.
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

  // Elaboration-time guard against illegal configurations.
  generate
    if (LATENCY < 1 || LATENCY > 4 || MEM_WORDS < 2 ||
        (MEM_WORDS & (MEM_WORDS - 1)) != 0 || ADDR_BASE[1:0] != 2'b00) begin : g_bad_params
      $error("dmem_responder: illegal parameter combination");
    end
  endgenerate

  logic              accept;
  logic [31:0]       off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic              s0_valid_d;
  logic              s0_err_d;
  logic [31:0]       s0_data_d;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [31:0]        data_q [LATENCY];

  logic [31:0]        mem_q [MEM_WORDS];

  // Grant is purely combinational and held off during reset.
  assign gnt_o    = req_i & ~busy_i & rst_n;
  assign accept   = req_i & gnt_o;

  // Wrapping subtract: addresses below the base become huge offsets and
  // therefore fall out of range naturally.
  assign off      = addr_i - ADDR_BASE;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  // Byte-enabled write port; the array is intentionally not reset so its
  // contents survive a core reset.
  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          mem_q[idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Stage-0 contents for the current cycle; data is zero unless this is an
  // in-range read so that idle and write responses never leak stale data.
  always_comb begin
    s0_valid_d = accept;
    s0_err_d   = accept & ~in_range;
    s0_data_d  = '0;
    if (accept && in_range && !we_i) begin
      s0_data_d = mem_q[idx];
    end
  end

  // Response shift pipeline; reset drops every in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < int'(LATENCY); s++) begin
        data_q[s] <= '0;
      end
    end else begin
      vld_q[0]  <= s0_valid_d;
      err_q[0]  <= s0_err_d;
      data_q[0] <= s0_data_d;
      for (int s = 1; s < int'(LATENCY); s++) begin
        vld_q[s]  <= vld_q[s-1];
        err_q[s]  <= err_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  assign rvalid_o = vld_q[LATENCY-1];
  assign err_o    = err_q[LATENCY-1];
  assign rdata_o  = data_q[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder. Instance A runs with
//             LATENCY=1, instance B with LATENCY=3. A reference memory model
//             predicts each response, which is queued at issue time and
//             compared when the matching rvalid pulse appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WORDS = 4096;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Instance A (LATENCY=1) signals
  logic        a_req, a_we, a_busy, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  // Instance B (LATENCY=3) signals
  logic        b_req, b_we, b_busy, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma[int];
  logic [31:0] mb[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .be_i(a_be), .wdata_i(a_wdata), .busy_i(a_busy), .gnt_o(a_gnt),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
  );

  dmem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .be_i(b_be), .wdata_i(b_wdata), .busy_i(b_busy), .gnt_o(b_gnt),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
  );

  // Response monitor, instance A: pop on each pulse, idle outputs must be zero.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (started) begin
      n_cmp++;
      if (a_rvalid === 1'b1) begin
        if (qa.size() == 0) begin
          n_bad++;
          $display("FAIL a_unexpected_rvalid cyc=%0d rdata=%h err=%b required no response", cyc, a_rdata, a_err);
        end else begin
          e = qa.pop_front();
          if (a_rdata !== e.data || a_err !== e.err || cyc != e.due) begin
            n_bad++;
            $display("FAIL a_response got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                     a_rdata, a_err, cyc, e.data, e.err, e.due);
          end
        end
      end else if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
        n_bad++;
        $display("FAIL a_idle_outputs got rvalid=%b rdata=%h err=%b required 0/0/0 cyc=%0d",
                 a_rvalid, a_rdata, a_err, cyc);
      end
    end
  end

  // Response monitor, instance B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (started) begin
      n_cmp++;
      if (b_rvalid === 1'b1) begin
        if (qb.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected_rvalid cyc=%0d rdata=%h err=%b required no response", cyc, b_rdata, b_err);
        end else begin
          e = qb.pop_front();
          if (b_rdata !== e.data || b_err !== e.err || cyc != e.due) begin
            n_bad++;
            $display("FAIL b_response got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                     b_rdata, b_err, cyc, e.data, e.err, e.due);
          end
        end
      end else if (b_rvalid !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
        n_bad++;
        $display("FAIL b_idle_outputs got rvalid=%b rdata=%h err=%b required 0/0/0 cyc=%0d",
                 b_rvalid, b_rdata, b_err, cyc);
      end
    end
  end

  // Issue one access on instance A (sel=0) or B (sel=1). The reference model
  // predicts the response, which is queued once the grant is observed. With
  // stall>0 busy_i is held high that many cycles and grant must stay low.
  task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input int stall);
    logic [31:0] off, cur, exp_d;
    logic        exp_e;
    int          idx, lat;
    bit          got;
    exp_t        e;
    off   = addr - BASE;
    idx   = int'(off[13:2]);
    lat   = sel ? 3 : 1;
    exp_d = 32'h0;
    exp_e = 1'b0;
    cur   = 32'h0;
    if (off >= 32'(4 * WORDS)) begin
      exp_e = 1'b1;
    end else begin
      if (sel) cur = mb.exists(idx) ? mb[idx] : 32'h0;
      else     cur = ma.exists(idx) ? ma[idx] : 32'h0;
      if (we) begin
        for (int n = 0; n < 4; n++) if (be[n]) cur[8*n +: 8] = wdata[8*n +: 8];
        if (sel) mb[idx] = cur; else ma[idx] = cur;
      end else begin
        exp_d = cur;
      end
    end
    @(negedge clk);
    if (sel) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wdata; b_busy = (stall > 0);
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata; a_busy = (stall > 0);
    end
    for (int s = 0; s < stall; s++) begin
      #1;
      n_cmp++;
      if ((sel ? b_gnt : a_gnt) !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_gnt stall cycle %0d got gnt=%b required 0", s, sel ? b_gnt : a_gnt);
      end
      @(negedge clk);
    end
    if (sel) b_busy = 1'b0; else a_busy = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if ((sel ? b_gnt : a_gnt) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout addr=%h got gnt=0 required gnt=1 within 20 cycles", addr);
      if (sel) b_req = 1'b0; else a_req = 1'b0;
    end else begin
      e.data = exp_d;
      e.err  = exp_e;
      e.due  = cyc + lat;
      if (sel) qb.push_back(e); else qa.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = BASE; a_be = 4'hF; a_wdata = '0; a_busy = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = BASE; b_be = 4'hF; b_wdata = '0; b_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gnt got a=%b b=%b required 0/0", a_gnt, b_gnt);
    end
    n_cmp++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0 ||
        b_rvalid !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got a=%b/%h/%b b=%b/%h/%b required all zero",
               a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, b_err);
    end
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    access(0, 1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 0);
    access(0, 1'b0, 32'h1000_0010, 4'hF, 32'h0, 0);
    idle(3);
  endtask

  task automatic test_byte_enables;
    access(0, 1'b1, 32'h1000_0020, 4'hF, 32'h1122_3344, 0);
    access(0, 1'b1, 32'h1000_0020, 4'b0101, 32'hAABB_CCDD, 0);
    access(0, 1'b0, 32'h1000_0020, 4'hF, 32'h0, 0);
    access(0, 1'b1, 32'h1000_0020, 4'b0000, 32'hFFFF_FFFF, 0);
    access(0, 1'b0, 32'h1000_0022, 4'hF, 32'h0, 0);
    idle(3);
  endtask

  task automatic test_out_of_range;
    access(0, 1'b1, 32'h1000_0000, 4'hF, 32'h5A5A_0001, 0);
    access(0, 1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0, 0);
    access(0, 1'b1, 32'h1000_4000, 4'hF, 32'hFFFF_FFFF, 0);
    access(0, 1'b0, 32'h1000_3FFC, 4'hF, 32'h0, 0);
    access(0, 1'b0, 32'h1000_0000, 4'hF, 32'h0, 0);
    idle(3);
  endtask

  task automatic test_busy_stall;
    access(0, 1'b0, 32'h1000_0010, 4'hF, 32'h0, 3);
    idle(4);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) access(1, 1'b1, BASE + 32'(4 * i), 4'hF, 32'(i), 0);
    access(1, 1'b1, BASE + 32'd20, 4'hF, 32'hCAFE_F00D, 0);
    for (int i = 0; i < 4; i++) access(1, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 0);
    idle(6);
  endtask

  task automatic test_reset_midflight;
    int pulses;
    access(1, 1'b0, BASE + 32'd4, 4'hF, 32'h0, 0);
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    qb.delete();
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) pulses++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL reset_drop got %0d rvalid pulses required 0", pulses);
    end
    access(1, 1'b0, BASE + 32'd20, 4'hF, 32'h0, 0);
    access(1, 1'b0, BASE + 32'd12, 4'hF, 32'h0, 0);
    idle(6);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_out_of_range();
    test_busy_stall();
    test_back_to_back();
    test_reset_midflight();
    idle(4);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending a=%0d b=%0d required 0/0", qa.size(), qb.size());
    end
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case anything above hangs.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
